rx_bit_sampler: RTL and testbench

- Upstream stage of the UART receive path.
- Synchronises the raw serial line and oversamples it by a programmable prescale factor.
- Detects the start bit, majority-votes each bit, and frames 8 data bits plus a stop bit.
- Drives the deserializer directly: sampled_bit, plus one deser_en pulse per data bit, LSB first.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/rx_sync_2ff.sv | 23 ++
 rtl/rx_bit_sampler.sv | 175 +++++++++++++++++
 tb/tb_rx_bit_sampler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: sampler states, frame defaults
// and the majority voter used for oversampled bits.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int MIN_PRESCALE   = 6;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; resets to 1 so an idle-high
// serial line shows no spurious edge when reset is released.
module rx_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Metastability filter: d -> meta_r -> q.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/rx_bit_sampler.sv
// UART receive front end: synchronises and oversamples rx_in, validates the
// start bit, majority-votes each bit and strobes data bits to the deserializer.
module rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  sampler_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  deser_en,
  output logic [3:0]            bit_cnt,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  stop_err,
  output logic                  start_glitch
);

  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] ZERO     = PRESCALE_W'(0);
  localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

  rx_state_e             state_r;
  logic                  rx_sync_s;
  logic                  rx_prev_r;
  logic [1:0]            warm_r;
  logic                  seen_high_r;
  logic                  s0_r;
  logic                  s1_r;
  logic [PRESCALE_W-1:0] p_r;
  logic [PRESCALE_W-1:0] edge_cnt_r;
  logic [PRESCALE_W-1:0] mid_s;
  logic [PRESCALE_W-1:0] p_in_s;
  logic                  s0_edge_s;
  logic                  s1_edge_s;
  logic                  vote_edge_s;
  logic                  bit_end_s;
  logic                  vote_s;
  logic                  fall_s;

  rx_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_sync_s)
  );

  // Sample-point decode, voter and start-edge detection.
  always_comb begin
    mid_s       = {1'b0, p_r[PRESCALE_W-1:1]};
    s0_edge_s   = (edge_cnt_r == (mid_s - ONE));
    s1_edge_s   = (edge_cnt_r == mid_s);
    vote_edge_s = (edge_cnt_r == (mid_s + ONE));
    bit_end_s   = (edge_cnt_r == (p_r - ONE));
    vote_s      = majority3(s0_r, s1_r, rx_sync_s);
    fall_s      = seen_high_r & rx_prev_r & ~rx_sync_s;
    if (prescale < MIN_P) begin
      p_in_s = MIN_P;
    end else begin
      p_in_s = prescale;
    end
  end

  // Line history and sample capture; seen_high_r only arms once the
  // synchroniser carries real line data, so a line stuck low after reset
  // cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_r   <= 1'b1;
      warm_r      <= 2'd0;
      seen_high_r <= 1'b0;
      s0_r        <= 1'b0;
      s1_r        <= 1'b0;
    end else begin
      rx_prev_r <= rx_sync_s;
      if (warm_r != 2'd2) begin
        warm_r <= warm_r + 2'd1;
      end
      if ((warm_r == 2'd2) && rx_sync_s) begin
        seen_high_r <= 1'b1;
      end
      if (s0_edge_s) begin
        s0_r <= rx_sync_s;
      end
      if (s1_edge_s) begin
        s1_r <= rx_sync_s;
      end
    end
  end

  // Frame FSM with registered strobes and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      p_r          <= MIN_P;
      edge_cnt_r   <= ZERO;
      bit_cnt      <= 4'd0;
      sampled_bit  <= 1'b0;
      deser_en     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      stop_err     <= 1'b0;
      start_glitch <= 1'b0;
    end else begin
      deser_en     <= 1'b0;
      frame_done   <= 1'b0;
      start_glitch <= 1'b0;
      if (!sampler_en) begin
        state_r <= IDLE;
        busy    <= 1'b0;
      end else begin
        if (state_r != IDLE) begin
          if (bit_end_s) begin
            edge_cnt_r <= ZERO;
          end else begin
            edge_cnt_r <= edge_cnt_r + ONE;
          end
        end
        case (state_r)
          IDLE: begin
            // The detection cycle is edge 0 of the start bit.
            if (fall_s) begin
              state_r    <= START;
              busy       <= 1'b1;
              p_r        <= p_in_s;
              edge_cnt_r <= ONE;
              bit_cnt    <= 4'd0;
            end
          end
          START: begin
            if (vote_edge_s && vote_s) begin
              state_r      <= IDLE;
              busy         <= 1'b0;
              start_glitch <= 1'b1;
            end else if (bit_end_s) begin
              state_r <= DATA;
              bit_cnt <= 4'd0;
            end
          end
          DATA: begin
            if (vote_edge_s) begin
              sampled_bit <= vote_s;
              deser_en    <= 1'b1;
            end else if (bit_end_s) begin
              if (bit_cnt == LAST_BIT) begin
                state_r <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          STOP: begin
            // Leave at mid-stop-bit so a back-to-back start edge is seen.
            if (vote_edge_s) begin
              frame_done <= 1'b1;
              stop_err   <= ~vote_s;
              state_r    <= IDLE;
              busy       <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Self-checking bench for rx_bit_sampler: directed frames plus randomized
// frames compared against a per-frame expectation built from bit timing rules.
module tb_rx_bit_sampler;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          sampler_en;
  logic [PW-1:0] prescale;
  logic          sampled_bit;
  logic          deser_en;
  logic [3:0]    bit_cnt;
  logic          busy;
  logic          frame_done;
  logic          stop_err;
  logic          start_glitch;

  rx_bit_sampler #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .sampler_en   (sampler_en),
    .prescale     (prescale),
    .sampled_bit  (sampled_bit),
    .deser_en     (deser_en),
    .bit_cnt      (bit_cnt),
    .busy         (busy),
    .frame_done   (frame_done),
    .stop_err     (stop_err),
    .start_glitch (start_glitch)
  );

  always #5 clk = ~clk;

  typedef struct { int stamp; int val; int idx; } ev_t;
  typedef struct { logic [7:0] data; bit stop; int p; int fall; } frm_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   glitch_cnt = 0;
  ev_t  deser_q[$];
  ev_t  done_q[$];
  frm_t exp_q[$];
  logic [7:0] rd;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT strobes away from the active edge.
  always @(negedge clk) begin
    if (deser_en === 1'b1) deser_q.push_back('{stamp: cyc, val: int'(sampled_bit), idx: int'(bit_cnt)});
    if (frame_done === 1'b1) done_q.push_back('{stamp: cyc, val: int'(stop_err), idx: 0});
    if (start_glitch === 1'b1) glitch_cnt = glitch_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) tick();
  endtask

  function automatic int eff_p(input int p);
    return (p < 6) ? 6 : p;
  endfunction

  task automatic clear_obs();
    deser_q.delete();
    done_q.delete();
    exp_q.delete();
    glitch_cnt = 0;
  endtask

  // Drive one frame; optionally glitch the centre of one bit, change prescale
  // mid-frame, or drop sampler_en mid-way through one bit.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int p,
                            input int glitch_bit, input int mid_ps, input int off_bit);
    frm_t f;
    int   pe;
    pe = eff_p(p);
    prescale = p[PW-1:0];
    f.data = d; f.stop = stop; f.p = p; f.fall = cyc;
    exp_q.push_back(f);
    rx_in = 1'b0;
    repeat (pe) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == 1 && mid_ps >= 0) prescale = mid_ps[PW-1:0];
      for (int t = 0; t < pe; t++) begin
        if (i == glitch_bit && t == pe / 2) rx_in = ~d[i];
        if (i == off_bit && t == pe / 2) sampler_en = 1'b0;
        tick();
        rx_in = d[i];
      end
    end
    rx_in = stop;
    prescale = p[PW-1:0];
    repeat (pe) tick();
    rx_in = 1'b1;
  endtask

  // Compare every observed strobe against the expected frames.
  task automatic verify_batch(input int exp_glitches);
    int   pe;
    int   first;
    int   lat;
    ev_t  e;
    check("deser_count", deser_q.size(), exp_q.size() * 8);
    check("done_count", done_q.size(), exp_q.size());
    check("glitch_count", glitch_cnt, exp_glitches);
    foreach (exp_q[f]) begin
      if (deser_q.size() < (f + 1) * 8 || done_q.size() < f + 1) break;
      pe    = eff_p(exp_q[f].p);
      first = deser_q[f * 8].stamp;
      lat   = first - exp_q[f].fall;
      check("latency_window", int'(lat >= pe + pe / 2 + 2 && lat <= pe + pe / 2 + 4), 1);
      for (int i = 0; i < 8; i++) begin
        e = deser_q[f * 8 + i];
        check("bit_val", e.val, int'(exp_q[f].data[i]));
        check("bit_idx", e.idx, i);
        if (i > 0) check("bit_spacing", e.stamp - deser_q[f * 8 + i - 1].stamp, pe);
      end
      check("done_time", done_q[f].stamp - first, 8 * pe);
      check("stop_err", done_q[f].val, int'(!exp_q[f].stop));
    end
    clear_obs();
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; sampler_en = 1'b1; prescale = 6'd8;
    repeat (3) tick();
    check("reset_outputs", {sampled_bit, deser_en, bit_cnt, busy, frame_done, stop_err, start_glitch}, 0);
    rst = 1'b0;
    idle(10);
    check("idle_busy", busy, 0);

    send_frame(8'h39, 1'b1, 8, -1, -1, -1);
    idle(20);
    verify_batch(0);

    // False start: low for two clocks only.
    rx_in = 1'b0;
    tick(); tick();
    idle(20);
    check("busy_after_glitch", busy, 0);
    verify_batch(1);
    send_frame(8'hA5, 1'b1, 8, -1, -1, -1);
    idle(20);
    verify_batch(0);

    send_frame(8'h00, 1'b0, 16, -1, -1, -1);
    idle(40);
    verify_batch(0);

    send_frame(8'hFF, 1'b1, 8, 3, -1, -1);
    idle(20);
    verify_batch(0);

    // Reset during bit 4 discards the frame.
    rd = 8'hC3; prescale = 6'd8;
    rx_in = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      rx_in = rd[i];
      repeat (8) tick();
    end
    rx_in = rd[4];
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("reset_midframe", {sampled_bit, deser_en, bit_cnt, busy, frame_done, stop_err, start_glitch}, 0);
    rst = 1'b0;
    idle(30);
    check("reset_partial_pulses", deser_q.size(), 4);
    check("reset_no_done", done_q.size(), 0);
    clear_obs();
    send_frame(8'h5A, 1'b1, 8, -1, -1, -1);
    idle(20);
    verify_batch(0);

    // Back-to-back frames; prescale changes during the first are ignored.
    send_frame(8'h12, 1'b1, 8, -1, 21, -1);
    send_frame(8'h34, 1'b1, 8, -1, -1, -1);
    idle(20);
    verify_batch(0);

    // sampler_en dropped mid bit 5: five strobes, then silence.
    send_frame(8'hC6, 1'b1, 8, -1, -1, 5);
    check("en_off_busy", busy, 0);
    idle(10);
    sampler_en = 1'b1;
    idle(20);
    check("en_off_pulses", deser_q.size(), 5);
    check("en_off_no_done", done_q.size(), 0);
    check("en_off_no_glitch", glitch_cnt, 0);
    clear_obs();

    // Prescale below the minimum runs at 6 clocks per bit.
    send_frame(8'h96, 1'b1, 3, -1, -1, -1);
    idle(20);
    verify_batch(0);

    for (int n = 0; n < 20; n++) begin
      send_frame(8'($urandom), 1'($urandom), int'($urandom_range(3, 30)),
                 int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 40)) - 1, -1);
      idle(40);
      verify_batch(0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
